// File: rtl/seq_detect_cnt.sv
// seq_detect_cnt: serial pattern detector with match counter and 2-digit multiplexed 7-segment display
module seq_detect_cnt #(
  parameter int PAT_LEN  = 3,
  parameter int CNT_W    = 8,
  parameter bit SAT      = 1'b1,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_vld,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [7:0]         seg,
  output logic [1:0]         an
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] win;
  logic [3:0]         fill;
  logic               match;
  logic [SW-1:0]      scan;
  logic [7:0]         d;
  assign win   = PAT_LEN'({hist, din});
  // fill guards against matching on reset zeros or bits consumed by a non-overlap match
  assign match = din_vld && !clr && win == pattern && fill >= 4'(PAT_LEN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      dout      <= 1'b0;
    end else begin
      dout <= match;
      if (clr) begin
        hist      <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end else if (din_vld) begin
        hist <= win;
        fill <= (match && !overlap) ? 4'd0 : (fill == 4'(PAT_LEN)) ? fill : fill + 4'd1;
        if (match) match_cnt <= (SAT && &match_cnt) ? match_cnt : match_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan <= '0;
      an   <= 2'b01;
    end else if (scan == SW'(SCAN_DIV - 1)) begin
      scan <= '0;
      an   <= {an[0], an[1]};
    end else begin
      scan <= scan + 1'b1;
    end
  assign d   = 8'(match_cnt);
  assign seg = SEG_LUT[an[1] ? d[7:4] : d[3:0]];
endmodule

// File: tb/tb_seq_detect_cnt.sv
// tb_seq_detect_cnt: randomized and directed checks of seq_detect_cnt against a stream-level model
module tb_seq_detect_cnt;
  localparam int P = 3;
  localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic clk = 1'b0, rst_n = 1'b1, din = 1'b0, din_vld = 1'b0, overlap = 1'b1, clr = 1'b0;
  logic [P-1:0] pattern = 3'b111;
  logic dout_a, dout_b;
  logic [7:0] cnt_a, seg_a, seg_b;
  logic [3:0] cnt_b;
  logic [1:0] an_a, an_b;
  int n_tests = 0, n_fail = 0;
  bit q[$];
  int fresh = 0, nmatch = 0, ticks = 0;
  bit exp_dout = 1'b0;

  always #5 clk = ~clk;

  seq_detect_cnt #(.PAT_LEN(P), .CNT_W(8), .SAT(1'b1), .SCAN_DIV(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .pattern(pattern),
    .overlap(overlap), .clr(clr), .dout(dout_a), .match_cnt(cnt_a), .seg(seg_a), .an(an_a));
  seq_detect_cnt #(.PAT_LEN(P), .CNT_W(4), .SAT(1'b0), .SCAN_DIV(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .pattern(pattern),
    .overlap(overlap), .clr(clr), .dout(dout_b), .match_cnt(cnt_b), .seg(seg_b), .an(an_b));

  function automatic logic [7:0] mcnt_a();
    return (nmatch > 255) ? 8'd255 : 8'(nmatch);
  endfunction
  function automatic logic [3:0] mcnt_b();
    return 4'(nmatch % 16);
  endfunction
  function automatic logic [1:0] exp_an(input int div);
    return ((ticks / div) % 2) ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [7:0] exp_seg(input logic [7:0] v, input int div);
    return SEG_TAB[((ticks / div) % 2) ? v[7:4] : v[3:0]];
  endfunction

  // drives one clock cycle and advances the stream model; returns #1 after the edge
  task automatic cycle(input bit d, input bit v, input bit c);
    bit m;
    @(negedge clk);
    din = d; din_vld = v; clr = c;
    @(posedge clk);
    m = v && !c && fresh >= P - 1;
    for (int j = 0; j < P; j++)
      if (m && pattern[j] != ((j == 0) ? d : q[q.size() - j])) m = 1'b0;
    if (c) begin
      q.delete(); fresh = 0; nmatch = 0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > 16) void'(q.pop_front());
      fresh = (m && !overlap) ? 0 : fresh + 1;
      if (m) nmatch++;
    end
    exp_dout = m;
    ticks++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b0; clr = 1'b0;
    q.delete(); fresh = 0; nmatch = 0; ticks = 0; exp_dout = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({dout_a, cnt_a, dout_b, cnt_b} !== 14'd0) begin
      n_fail++; $display("FAIL reset_state got dout/cnt %b/%h %b/%h want 0", dout_a, cnt_a, dout_b, cnt_b);
    end
    n_tests++;
    if ({an_a, seg_a, an_b, seg_b} !== {2'b01, 8'h3F, 2'b01, 8'h3F}) begin
      n_fail++; $display("FAIL reset_display got an/seg %b/%h %b/%h want 01/3f", an_a, seg_a, an_b, seg_b);
    end
    release_reset();
  endtask

  task automatic test_seq(input string name, input logic [2:0] pat, input bit ov,
                          input int n, input logic [7:0] bits, input int exp_n);
    pattern = pat; overlap = ov;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      cycle(bits[n - 1 - i], 1'b1, 1'b0);
      n_tests++;
      if ({dout_a, dout_b} !== {exp_dout, exp_dout}) begin
        n_fail++; $display("FAIL %s_dout bit%0d got %b%b want %b", name, i, dout_a, dout_b, exp_dout);
      end
    end
    n_tests++;
    if (cnt_a !== 8'(exp_n) || cnt_b !== 4'(exp_n)) begin
      n_fail++; $display("FAIL %s_cnt got %0d/%0d want %0d", name, cnt_a, cnt_b, exp_n);
    end
  endtask

  task automatic test_clr_gap();
    logic [2:0] stim [9] = '{3'b110, 3'b110, 3'b111, 3'b110, 3'b000, 3'b110, 3'b000, 3'b000, 3'b110};
    pattern = 3'b111; overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(stim[i][2], stim[i][1], stim[i][0]);
      n_tests++;
      if ({dout_a, dout_b, cnt_a, cnt_b} !== {exp_dout, exp_dout, mcnt_a(), mcnt_b()}) begin
        n_fail++; $display("FAIL clr_gap step%0d got %b%b/%0d/%0d want %b/%0d", i, dout_a, dout_b, cnt_a, cnt_b, exp_dout, nmatch);
      end
    end
    n_tests++;
    if ({dout_a, cnt_a} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL clr_gap_final got %b/%0d want 1/1", dout_a, cnt_a);
    end
  endtask

  task automatic test_saturate();
    pattern = 3'b111; overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 262; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({dout_a, dout_b, cnt_a, cnt_b} !== {exp_dout, exp_dout, mcnt_a(), mcnt_b()}) begin
        n_fail++; $display("FAIL saturate step%0d got %b%b/%0d/%0d want %b/%0d", i, dout_a, dout_b, cnt_a, cnt_b, exp_dout, nmatch);
      end
      if (i == 19) begin
        n_tests++;
        if (cnt_b !== 4'h1) begin
          n_fail++; $display("FAIL wrap_17 got %h want 1", cnt_b);
        end
      end
    end
    n_tests++;
    if ({dout_a, cnt_a, cnt_b} !== {1'b1, 8'hFF, 4'h4}) begin
      n_fail++; $display("FAIL sat_hold got %b/%h/%h want 1/ff/4", dout_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_display();
    pattern = 3'b111; overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (44) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({an_a, seg_a, an_b, seg_b} !== {exp_an(4), exp_seg(mcnt_a(), 4), exp_an(3), exp_seg({4'h0, mcnt_b()}, 3)}) begin
        n_fail++; $display("FAIL display c%0d got %b/%h %b/%h want %b/%h %b/%h", i, an_a, seg_a, an_b, seg_b,
                           exp_an(4), exp_seg(mcnt_a(), 4), exp_an(3), exp_seg({4'h0, mcnt_b()}, 3));
      end
      n_tests++;
      if (seg_a !== ((an_a == 2'b01) ? 8'h77 : 8'h5B)) begin
        n_fail++; $display("FAIL display_2a got an=%b seg=%h", an_a, seg_a);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      overlap = 1'($urandom);
      if ($urandom_range(15) == 0) pattern = 3'($urandom);
      cycle(1'($urandom), $urandom_range(3) != 0, $urandom_range(31) == 0);
      n_tests++;
      if ({dout_a, dout_b, cnt_a, cnt_b} !== {exp_dout, exp_dout, mcnt_a(), mcnt_b()}) begin
        n_fail++; $display("FAIL random c%0d got %b%b/%0d/%0d want %b/%0d", i, dout_a, dout_b, cnt_a, cnt_b, exp_dout, nmatch);
      end
      n_tests++;
      if ({an_a, seg_a} !== {exp_an(4), exp_seg(mcnt_a(), 4)}) begin
        n_fail++; $display("FAIL random_disp c%0d got %b/%h want %b/%h", i, an_a, seg_a, exp_an(4), exp_seg(mcnt_a(), 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    pattern = 3'b111; overlap = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (9) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    n_tests++;
    if ({dout_a, cnt_a, cnt_b, an_a} !== {1'b0, 8'd0, 4'd0, 2'b01}) begin
      n_fail++; $display("FAIL async_reset got %b/%0d/%0d/%b want 0/0/0/01", dout_a, cnt_a, cnt_b, an_a);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_tests++;
      if (dout_a !== (i == 2)) begin
        n_fail++; $display("FAIL reset_mid_dout bit%0d got %b want %b", i, dout_a, i == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq("ov111", 3'b111, 1'b1, 4, 8'b1111, 2);
    test_seq("nov111", 3'b111, 1'b0, 4, 8'b1111, 1);
    test_seq("ov101", 3'b101, 1'b1, 5, 8'b10101, 2);
    test_seq("nov101", 3'b101, 1'b0, 5, 8'b10101, 1);
    test_clr_gap();
    test_saturate();
    test_display();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_cnt.md
SEQ_DETECT_CNT -- requirements
Module: seq_detect_cnt

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits, legal range 1..8.
REQ-002 Parameter CNT_W, default 8: match counter width, legal range 2..16.
REQ-003 Parameter SAT, default 1: 1 = counter saturates at all-ones, 0 = counter wraps to zero.
REQ-004 Parameter SCAN_DIV, default 50000: clk cycles per display digit slot, legal range >= 2.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 din  input  1  serial data bit.
REQ-008 din_vld  input  1  din is sampled only in cycles where din_vld=1.
REQ-009 pattern  input  PAT_LEN  target sequence; pattern[PAT_LEN-1] is the first bit received, pattern[0] the last.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 clr  input  1  synchronous clear of history and counter.
REQ-012 dout  output  1  one-cycle match pulse, registered.
REQ-013 match_cnt  output  CNT_W  number of matches, registered.
REQ-014 seg  output  8  7-segment code, active-high, bit order {dp,g,f,e,d,c,b,a}; dp always 0.
REQ-015 an  output  2  digit select, active-high, one-hot.

Function
REQ-016 Shift register hist[PAT_LEN-1:0]: on each din_vld=1 cycle (clr=0), hist shifts left and din enters at hist[0].
REQ-017 Fill counter fill (saturating at PAT_LEN) counts accepted bits since reset, clr, or a non-overlap match.
REQ-018 Match condition: din_vld=1, clr=0, {hist[PAT_LEN-2:0],din}==pattern, and fill>=PAT_LEN-1; pattern and overlap are sampled in that same cycle.
REQ-019 On a match, dout=1 in the following cycle only; dout=0 in all other cycles, including back-to-back matches separated by at least one cycle.
REQ-020 Consecutive matching din_vld cycles produce dout high in consecutive cycles.
REQ-021 match_cnt increments on the same edge that sets dout, so it already includes the match in the cycle dout=1.
REQ-022 Overlap=1: history and fill are retained after a match.
REQ-023 Overlap=0: after a match, fill is cleared to 0, so the next match needs PAT_LEN fresh bits.
REQ-024 Counter at all-ones with a new match: with SAT=1 it holds at all-ones and dout still pulses; with SAT=0 it wraps to 0.
REQ-025 din_vld=0 cycle: hist, fill and match_cnt hold; dout=0 next cycle.
REQ-026 clr=1 cycle: hist, fill and match_cnt are cleared to 0 and dout=0 next cycle; clr has priority over a simultaneous din_vld, whose bit is discarded.
REQ-027 Display value D = low 8 bits of match_cnt, zero-extended when CNT_W<8.
REQ-028 Scan counter runs 0..SCAN_DIV-1 continuously, independent of din_vld and clr.
REQ-029 an toggles between 2'b01 and 2'b10 when the scan counter wraps.
REQ-030 an=2'b01 displays D[3:0]; an=2'b10 displays D[7:4].
REQ-031 seg is decoded combinationally from the selected nibble:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-032 Pattern change mid-stream is legal; the comparison uses the new value from that cycle onward and existing history is not flushed.

Reset
REQ-033 rst_n=0 asynchronously sets hist=0, fill=0, match_cnt=0, dout=0, scan counter=0, an=2'b01, so seg=8'h3F.
REQ-034 Deassertion of rst_n takes effect at the first rising edge after release; no din is accepted before that edge.
REQ-035 Reset asserted mid-sequence discards partial history; no dout pulse is produced for bits received before reset.

Verification
REQ-036 PAT_LEN=3, pattern=3'b111, overlap=1, din_vld=1, din=1,1,1,1 -> dout high in the cycles after the 3rd and 4th bits; match_cnt=2.
REQ-037 Same stimulus with overlap=0 -> one dout pulse, after the 3rd bit; match_cnt=1.
REQ-038 pattern=3'b101, din=1,0,1,0,1 -> overlap=1 gives match_cnt=2; overlap=0 gives match_cnt=1.
REQ-039 CNT_W=4, 17 matches -> SAT=1 gives match_cnt=4'hF; SAT=0 gives match_cnt=4'h1.
REQ-040 clr asserted together with the completing bit of 111 -> no dout pulse and match_cnt=0; din_vld gaps inside a pattern do not break the match.
REQ-041 Force match_cnt to 8'h2A, SCAN_DIV=4 -> an=01 with seg=8'h77 for 4 cycles, then an=10 with seg=8'h5B, alternating.
